proc_datapath: RTL and testbench

- Datapath responder for the 4-register processor control FSM.
- Consumes the FSM's registered control strobes (Rin, Rout, Ain, Gin, Gout, addsub, externx, Done) and owns the shared bus, R0..R3, operand register A, result register G and the adder/subtractor.
- Adds bus-contention detection and a completed-instruction counter, so the FSM+datapath pair can be verified end to end.

---
 rtl/proc_datapath.sv | 112 +++++++++++
 tb/tb_proc_datapath.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_datapath.sv
// Processor datapath: shared bus, R0..R3, operand A, result G, adder/subtractor,
// sticky bus-contention flag and completed-instruction counter.
// Optional ALU flags are built when PROC_DP_FLAGS_EN is defined; otherwise the
// flag outputs are tied to zero and no flag logic exists.
module proc_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       Rin,
  input  logic [3:0]       Rout,
  input  logic             Ain,
  input  logic             Gin,
  input  logic             Gout,
  input  logic             addsub,
  input  logic             externx,
  input  logic             Done,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] g_q,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned NDRV = 6;
  localparam int unsigned MSB  = WIDTH - 1;

  logic [WIDTH-1:0] regs [4];
  logic [NDRV-1:0]  drv;
  logic             contention;
  logic [WIDTH-1:0] alu_res;

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];

  // More than one bus driver active: clearing the lowest set bit leaves something
  assign drv        = {externx, Gout, Rout};
  assign contention = (drv & (drv - NDRV'(1))) != '0;

  // Fixed-priority bus mux; bus idles at zero
  always_comb begin
    bus = '0;
    if (externx)      bus = din;
    else if (Gout)    bus = g_q;
    else if (Rout[0]) bus = regs[0];
    else if (Rout[1]) bus = regs[1];
    else if (Rout[2]) bus = regs[2];
    else if (Rout[3]) bus = regs[3];
  end

`ifdef PROC_DP_FLAGS_EN
  logic [WIDTH:0] ext_sum;
  logic           carry_c;
  logic           ovf_c;

  // Extended add/sub so the carry/borrow bit is visible
  assign ext_sum = addsub ? ({1'b0, a_q} + {1'b0, bus}) : ({1'b0, a_q} - {1'b0, bus});
  assign alu_res = ext_sum[WIDTH-1:0];
  assign carry_c = addsub ? ext_sum[WIDTH] : ~ext_sum[WIDTH];
  assign ovf_c   = addsub ? ((a_q[MSB] == bus[MSB]) && (alu_res[MSB] != a_q[MSB]))
                          : ((a_q[MSB] != bus[MSB]) && (alu_res[MSB] != a_q[MSB]));

  // Flags follow every G load and hold otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (Gin) begin
      flag_z <= (alu_res == '0);
      flag_c <= carry_c;
      flag_v <= ovf_c;
    end
  end
`else
  assign alu_res = addsub ? (a_q + bus) : (a_q - bus);
  assign flag_z  = 1'b0;
  assign flag_c  = 1'b0;
  assign flag_v  = 1'b0;
`endif

  // Register file, operand/result registers, error flag and counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) regs[k] <= '0;
      a_q       <= '0;
      g_q       <= '0;
      err       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (Rin[k]) regs[k] <= bus;
      end
      if (Ain)        a_q       <= bus;
      if (Gin)        g_q       <= alu_res;
      if (contention) err       <= 1'b1;
      if (Done)       instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_proc_datapath.sv
// Scoreboard bench for proc_datapath: driver pushes expected bus and post-edge
// state from a behavioural model; independent monitors pop and compare.
module tb_proc_datapath;

  localparam int unsigned W    = 8;
  localparam int unsigned CW   = 4;
  localparam int          DMOD = 256;
  localparam int          CMOD = 16;
`ifdef PROC_DP_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  din = '0;
  logic [3:0]    Rin = '0;
  logic [3:0]    Rout = '0;
  logic          Ain = 1'b0, Gin = 1'b0, Gout = 1'b0, addsub = 1'b0, externx = 1'b0, Done = 1'b0;
  logic [W-1:0]  bus, r0, r1, r2, r3, a_q, g_q;
  logic          err, flag_z, flag_c, flag_v;
  logic [CW-1:0] instr_cnt;

  always #5 clk = ~clk;

  proc_datapath #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .addsub(addsub), .externx(externx), .Done(Done), .bus(bus),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .a_q(a_q), .g_q(g_q), .err(err),
    .instr_cnt(instr_cnt), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  typedef struct packed {
    logic [3:0][W-1:0] r;
    logic [W-1:0]      a;
    logic [W-1:0]      g;
    logic              err;
    logic [CW-1:0]     cnt;
    logic [2:0]        fl;
  } st_t;

  st_t          exp_q[$];
  logic [W-1:0] bus_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state (plain integers)
  int m_r[4];
  int m_a, m_g, m_cnt;
  bit m_err, m_z, m_c, m_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= DMOD / 2) ? v - DMOD : v;
  endfunction

  // Apply one cycle of strobes and predict the bus now and the state after the edge
  task automatic step(input bit rs, input int d, input logic [3:0] ri, input logic [3:0] ro,
                      input bit ain, input bit gin, input bit gout, input bit as,
                      input bit ex, input bit dn);
    int   cands[$];
    int   b, res, sr;
    bit   c;
    st_t  e;
    rst = rs; din = W'(d); Rin = ri; Rout = ro; Ain = ain; Gin = gin;
    Gout = gout; addsub = as; externx = ex; Done = dn;

    if (ex)   cands.push_back(d % DMOD);
    if (gout) cands.push_back(m_g);
    for (int k = 0; k < 4; k++) if (ro[k]) cands.push_back(m_r[k]);
    b = (cands.size() > 0) ? cands[0] : 0;
    bus_q.push_back(W'(b));

    if (!rs) begin
      for (int k = 0; k < 4; k++) m_r[k] = 0;
      m_a = 0; m_g = 0; m_cnt = 0; m_err = 0; m_z = 0; m_c = 0; m_v = 0;
    end else begin
      if (as) begin
        res = (m_a + b) % DMOD;
        c   = (m_a + b) >= DMOD;
        sr  = to_signed(m_a) + to_signed(b);
      end else begin
        res = (m_a - b + DMOD) % DMOD;
        c   = m_a >= b;
        sr  = to_signed(m_a) - to_signed(b);
      end
      if (FLAGS && gin) begin
        m_z = (res == 0);
        m_c = c;
        m_v = (sr > DMOD / 2 - 1) || (sr < -(DMOD / 2));
      end
      if (gin) m_g = res;
      if (ain) m_a = b;
      for (int k = 0; k < 4; k++) if (ri[k]) m_r[k] = b;
      if (cands.size() > 1) m_err = 1;
      if (dn) m_cnt = (m_cnt + 1) % CMOD;
    end

    for (int k = 0; k < 4; k++) e.r[k] = W'(m_r[k]);
    e.a = W'(m_a); e.g = W'(m_g); e.err = m_err; e.cnt = CW'(m_cnt);
    e.fl = {m_z, m_c, m_v};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
  endtask

  // Bus monitor: combinational bus, sampled mid-cycle after the driver settles
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus_q.size() > 0) chk("bus", 64'(bus), 64'(bus_q.pop_front()));
    end
  end

  // State monitor: post-edge register contents
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regs",  64'({r3, r2, r1, r0}), 64'(e.r));
        chk("a_q",   64'(a_q), 64'(e.a));
        chk("g_q",   64'(g_q), 64'(e.g));
        chk("err",   64'(err), 64'(e.err));
        chk("instr_cnt", 64'(instr_cnt), 64'(e.cnt));
        chk("flags", 64'({flag_z, flag_c, flag_v}), 64'(e.fl));
      end
    end
  end

  initial begin
    int ro_sel;
    logic [3:0] ro;
    for (int k = 0; k < 4; k++) m_r[k] = 0;
    m_a = 0; m_g = 0; m_cnt = 0; m_err = 0; m_z = 0; m_c = 0; m_v = 0;
    @(negedge clk);
    // args: rs, din, Rin, Rout, Ain, Gin, Gout, addsub, externx, Done
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    // Load and move
    step(1, 'h25, 4'b0001, 4'b0000, 0, 0, 0, 0, 1, 1);
    step(1, 0,    4'b0100, 4'b0001, 0, 0, 0, 0, 0, 1);
    // Add with wrap: r1=F0, r2=20
    step(1, 'hF0, 4'b0010, 4'b0000, 0, 0, 0, 0, 1, 0);
    step(1, 'h20, 4'b0100, 4'b0000, 0, 0, 0, 0, 1, 0);
    step(1, 0, 4'b0000, 4'b0010, 1, 0, 0, 1, 0, 0);
    step(1, 0, 4'b0000, 4'b0100, 0, 1, 0, 1, 0, 0);
    step(1, 0, 4'b0010, 4'b0000, 0, 0, 1, 0, 0, 1);
    // Subtract to zero: r0=05, r3=05
    step(1, 'h05, 4'b1001, 4'b0000, 0, 0, 0, 0, 1, 0);
    step(1, 0, 4'b0000, 4'b0001, 1, 0, 0, 0, 0, 0);
    step(1, 0, 4'b0000, 4'b1000, 0, 1, 0, 0, 0, 0);
    step(1, 0, 4'b0001, 4'b0000, 0, 0, 1, 0, 0, 1);
    // Simultaneous events: Rin/Rout same reg, Gin+Gout, Ain+Gin
    step(1, 0, 4'b0010, 4'b0010, 0, 0, 0, 0, 0, 0);
    step(1, 0, 4'b0000, 4'b0000, 0, 1, 1, 1, 0, 0);
    step(1, 0, 4'b0000, 4'b0010, 1, 1, 0, 0, 0, 0);
    // Contention: err sets and sticks until reset
    step(1, 'h55, 4'b1000, 4'b0000, 0, 0, 0, 0, 1, 0);
    step(1, 'hAA, 4'b0000, 4'b1000, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    // Reset mid-op: Ain cycle then reset together with Gin
    step(1, 'h33, 4'b0010, 4'b0000, 0, 0, 0, 0, 1, 1);
    step(1, 0, 4'b0000, 4'b0010, 1, 0, 0, 1, 0, 0);
    step(0, 0, 4'b0000, 4'b0010, 0, 1, 0, 1, 0, 0);
    // Counter wrap: Done held across the wrap point
    repeat (CMOD + 3) step(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
    // Randomized traffic
    repeat (500) begin
      ro_sel = $urandom_range(0, 9);
      if (ro_sel <= 3)      ro = 4'(1 << ro_sel);
      else if (ro_sel == 7) ro = 4'($urandom_range(0, 15));
      else                  ro = 4'b0000;
      step($urandom_range(0, 39) != 0, $urandom_range(0, 255), 4'($urandom_range(0, 15)) & {4{$urandom_range(0, 1) == 1}},
           ro, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end
    idle();
    repeat (2) @(negedge clk);
    chk("drain", 64'(exp_q.size() + bus_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
